// File: rtl/cfg_chain_arb.sv
// Two-port arbiter for the filter's serial configuration chain.
// Grants one port at a time, checks the shift count before a download and revokes a stalled owner.
module cfg_chain_arb #(
    parameter int CHAIN_LEN = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req_in,
    output logic       a_gnt_out,
    input  logic       a_ul_in,
    input  logic       a_dl_in,
    input  logic       a_sde_in,
    input  logic       a_sd_in,
    output logic       a_sd_out,
    input  logic       b_req_in,
    output logic       b_gnt_out,
    input  logic       b_ul_in,
    input  logic       b_dl_in,
    input  logic       b_sde_in,
    input  logic       b_sd_in,
    output logic       b_sd_out,
    output logic       ul_out,
    output logic       dl_out,
    output logic       sde_out,
    output logic       sd_out,
    input  logic       sd_in,
    output logic [1:0] owner_out,
    output logic       err_out,
    output logic [1:0] err_code_out
);

    localparam int SC_W = $clog2(CHAIN_LEN + 2);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] SC_FULL = SC_W'(CHAIN_LEN);
    localparam logic [SC_W-1:0] SC_SAT  = SC_W'(CHAIN_LEN + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_ILL_DL  = 2'b10;

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;

    state_t          state_reg, state_next;
    logic            last_b_reg, last_b_next;
    logic            blk_a_reg, blk_a_next;
    logic            blk_b_reg, blk_b_next;
    logic [SC_W-1:0] shift_cnt_reg, shift_cnt_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            err_reg, err_next;
    logic [1:0]      err_code_reg, err_code_next;

    logic own_a, own_b, owned;
    logic o_req, o_ul, o_dl, o_sde, o_sd;
    logic dl_ok, activity, timeout;
    logic elig_a, elig_b;

    // Owner selection depends only on registered state, so strobes never switch mid-cycle.
    assign own_a = (state_reg == OWN_A);
    assign own_b = (state_reg == OWN_B);
    assign owned = own_a | own_b;

    assign o_req = own_a ? a_req_in : b_req_in;
    assign o_ul  = own_a ? a_ul_in  : b_ul_in;
    assign o_dl  = own_a ? a_dl_in  : b_dl_in;
    assign o_sde = own_a ? a_sde_in : b_sde_in;
    assign o_sd  = own_a ? a_sd_in  : b_sd_in;

    assign dl_ok    = (shift_cnt_reg == SC_FULL);
    assign activity = owned & (o_ul | o_dl | o_sde);
    assign timeout  = owned & ~activity & (to_cnt_reg == TO_LAST);

    assign ul_out       = owned & o_ul;
    assign sde_out      = owned & o_sde;
    assign sd_out       = owned & o_sd;
    assign dl_out       = owned & o_dl & dl_ok;
    assign a_sd_out     = own_a & sd_in;
    assign b_sd_out     = own_b & sd_in;
    assign a_gnt_out    = own_a;
    assign b_gnt_out    = own_b;
    assign owner_out    = {own_b, own_a};
    assign err_out      = err_reg;
    assign err_code_out = err_code_reg;

    assign elig_a = a_req_in & ~blk_a_reg;
    assign elig_b = b_req_in & ~blk_b_reg;

    always_comb begin
        state_next     = state_reg;
        last_b_next    = last_b_reg;
        blk_a_next     = blk_a_reg;
        blk_b_next     = blk_b_reg;
        shift_cnt_next = shift_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        err_next       = 1'b0;
        err_code_next  = err_code_reg;

        if (!a_req_in) blk_a_next = 1'b0;
        if (!b_req_in) blk_b_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (elig_a && (!elig_b || last_b_reg)) begin
                    state_next     = OWN_A;
                    shift_cnt_next = '0;
                    to_cnt_next    = '0;
                end else if (elig_b) begin
                    state_next     = OWN_B;
                    shift_cnt_next = '0;
                    to_cnt_next    = '0;
                end
            end
            OWN_A, OWN_B: begin
                to_cnt_next = activity ? '0 : to_cnt_reg + 1'b1;
                // A download attempt always restarts the count, legal or not.
                if (o_dl || o_ul)
                    shift_cnt_next = '0;
                else if (o_sde && shift_cnt_reg != SC_SAT)
                    shift_cnt_next = shift_cnt_reg + 1'b1;

                if (timeout) begin
                    err_next      = 1'b1;
                    err_code_next = CODE_TIMEOUT;
                    state_next    = GAP;
                    last_b_next   = own_b;
                    if (own_a) blk_a_next = 1'b1;
                    else       blk_b_next = 1'b1;
                end else begin
                    if (o_dl && !dl_ok) begin
                        err_next      = 1'b1;
                        err_code_next = CODE_ILL_DL;
                    end
                    if (!o_req) begin
                        state_next  = GAP;
                        last_b_next = own_b;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_b_reg    <= 1'b1;
            blk_a_reg     <= 1'b0;
            blk_b_reg     <= 1'b0;
            shift_cnt_reg <= '0;
            to_cnt_reg    <= '0;
            err_reg       <= 1'b0;
            err_code_reg  <= 2'b00;
        end else begin
            state_reg     <= state_next;
            last_b_reg    <= last_b_next;
            blk_a_reg     <= blk_a_next;
            blk_b_reg     <= blk_b_next;
            shift_cnt_reg <= shift_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

endmodule

// File: tb/tb_cfg_chain_arb.sv
// Scoreboard bench for cfg_chain_arb: expectations are queued with each cycle's stimulus
// and compared against the DUT outputs at the following falling edge.
module tb_cfg_chain_arb;

    localparam int CL = 8;
    localparam int TO = 16;

    localparam int S_AGNT = 0, S_BGNT = 1, S_UL = 2, S_DL = 3, S_SDE = 4, S_SD = 5;
    localparam int S_ASD = 6, S_BSD = 7, S_OWN = 8, S_ERR = 9, S_CODE = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req_in = 0, a_ul_in = 0, a_dl_in = 0, a_sde_in = 0, a_sd_in = 0;
    logic       b_req_in = 0, b_ul_in = 0, b_dl_in = 0, b_sde_in = 0, b_sd_in = 0;
    logic       sd_in = 0;
    logic       a_gnt_out, a_sd_out, b_gnt_out, b_sd_out;
    logic       ul_out, dl_out, sde_out, sd_out, err_out;
    logic [1:0] owner_out, err_code_out;

    cfg_chain_arb #(.CHAIN_LEN(CL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_in(a_req_in), .a_gnt_out(a_gnt_out), .a_ul_in(a_ul_in), .a_dl_in(a_dl_in),
        .a_sde_in(a_sde_in), .a_sd_in(a_sd_in), .a_sd_out(a_sd_out),
        .b_req_in(b_req_in), .b_gnt_out(b_gnt_out), .b_ul_in(b_ul_in), .b_dl_in(b_dl_in),
        .b_sde_in(b_sde_in), .b_sd_in(b_sd_in), .b_sd_out(b_sd_out),
        .ul_out(ul_out), .dl_out(dl_out), .sde_out(sde_out), .sd_out(sd_out), .sd_in(sd_in),
        .owner_out(owner_out), .err_out(err_out), .err_code_out(err_code_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_sig(input int s);
        logic [31:0] r;
        r = '0;
        case (s)
            S_AGNT: r[0]   = a_gnt_out;
            S_BGNT: r[0]   = b_gnt_out;
            S_UL:   r[0]   = ul_out;
            S_DL:   r[0]   = dl_out;
            S_SDE:  r[0]   = sde_out;
            S_SD:   r[0]   = sd_out;
            S_ASD:  r[0]   = a_sd_out;
            S_BSD:  r[0]   = b_sd_out;
            S_OWN:  r[1:0] = owner_out;
            S_ERR:  r[0]   = err_out;
            S_CODE: r[1:0] = err_code_out;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic exp_sig(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_all_zero(input string pfx);
        for (int s = 0; s <= S_CODE; s++)
            exp_sig($sformatf("%s_%0d", pfx, s), s, 0);
    endtask

    // Sample at the falling edge, then move to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, get_sig(e.sig), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        pat = 8'b10110010;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        exp_all_zero("rst");
        tick();
        rst_n = 1'b1;

        // port A full legal transfer
        a_req_in = 1;
        exp_sig("t1_gnt_pre", S_AGNT, 0);
        tick();
        a_ul_in = 1;
        exp_sig("t1_gnt", S_AGNT, 1);
        exp_sig("t1_own", S_OWN, 1);
        exp_sig("t1_ul", S_UL, 1);
        tick();
        a_ul_in = 0;
        for (int i = 0; i < 8; i++) begin
            a_sde_in = 1;
            a_sd_in  = pat[7-i];
            sd_in    = 1'($urandom_range(0, 1));
            b_sd_in  = ~pat[7-i];
            exp_sig($sformatf("t1_sde%0d", i), S_SDE, 1);
            exp_sig($sformatf("t1_sd%0d", i), S_SD, pat[7-i]);
            exp_sig($sformatf("t1_asd%0d", i), S_ASD, sd_in);
            exp_sig($sformatf("t1_bsd%0d", i), S_BSD, 0);
            tick();
        end
        a_sde_in = 0; a_sd_in = 0; b_sd_in = 0;
        a_dl_in = 1;
        exp_sig("t1_dl", S_DL, 1);
        exp_sig("t1_err_dl", S_ERR, 0);
        tick();
        a_dl_in = 0; a_req_in = 0;
        exp_sig("t1_err_after", S_ERR, 0);
        exp_sig("t1_own_last", S_OWN, 1);
        tick();
        exp_sig("t1_gap_own", S_OWN, 0);
        exp_sig("t1_gap_gnt", S_AGNT, 0);
        tick();
        exp_sig("t1_idle_own", S_OWN, 0);
        tick();

        // port B short and overrun downloads
        b_req_in = 1;
        tick();
        b_ul_in = 1;
        exp_sig("t2_gnt", S_BGNT, 1);
        exp_sig("t2_own", S_OWN, 2);
        exp_sig("t2_ul", S_UL, 1);
        tick();
        b_ul_in = 0;
        for (int i = 0; i < 7; i++) begin
            b_sde_in = 1;
            b_sd_in  = 1'($urandom_range(0, 1));
            exp_sig($sformatf("t2_sd%0d", i), S_SD, b_sd_in);
            tick();
        end
        b_sde_in = 0;
        b_dl_in = 1;
        exp_sig("t2_dl_short", S_DL, 0);
        tick();
        b_dl_in = 0;
        exp_sig("t2_err_short", S_ERR, 1);
        exp_sig("t2_code_short", S_CODE, 2);
        tick();
        exp_sig("t2_err_once", S_ERR, 0);
        exp_sig("t2_code_hold", S_CODE, 2);
        tick();
        for (int i = 0; i < 9; i++) begin
            b_sde_in = 1;
            tick();
        end
        b_sde_in = 0;
        b_dl_in = 1;
        exp_sig("t2_dl_over", S_DL, 0);
        tick();
        b_dl_in = 0; b_req_in = 0;
        exp_sig("t2_err_over", S_ERR, 1);
        exp_sig("t2_code_over", S_CODE, 2);
        tick();
        exp_sig("t2_gap_gnt", S_BGNT, 0);
        tick();
        tick();

        // simultaneous requests and round robin
        a_req_in = 1; b_req_in = 1;
        exp_sig("t3_idle_a", S_AGNT, 0);
        exp_sig("t3_idle_b", S_BGNT, 0);
        tick();
        a_req_in = 0;
        exp_sig("t3_a_first", S_AGNT, 1);
        exp_sig("t3_b_wait", S_BGNT, 0);
        exp_sig("t3_own_a", S_OWN, 1);
        tick();
        exp_sig("t3_gap_a", S_AGNT, 0);
        exp_sig("t3_gap_b", S_BGNT, 0);
        exp_sig("t3_gap_own", S_OWN, 0);
        tick();
        exp_sig("t3_idle_b2", S_BGNT, 0);
        exp_sig("t3_idle_own", S_OWN, 0);
        tick();
        a_req_in = 1; b_req_in = 0;
        exp_sig("t3_b_gnt", S_BGNT, 1);
        exp_sig("t3_own_b", S_OWN, 2);
        tick();
        b_req_in = 1;
        exp_sig("t3_gap2_own", S_OWN, 0);
        tick();
        exp_sig("t3_idle2_own", S_OWN, 0);
        tick();

        // A idle owner times out while B strobes are ignored
        for (int i = 0; i < TO; i++) begin
            b_sde_in = 1'($urandom_range(0, 1));
            b_dl_in  = 1'($urandom_range(0, 1));
            b_ul_in  = 1'($urandom_range(0, 1));
            b_sd_in  = 1'($urandom_range(0, 1));
            sd_in    = 1'($urandom_range(0, 1));
            exp_sig($sformatf("t4_agnt%0d", i), S_AGNT, 1);
            exp_sig($sformatf("t4_bgnt%0d", i), S_BGNT, 0);
            exp_sig($sformatf("t4_ul%0d", i), S_UL, 0);
            exp_sig($sformatf("t4_dl%0d", i), S_DL, 0);
            exp_sig($sformatf("t4_sde%0d", i), S_SDE, 0);
            exp_sig($sformatf("t4_sd%0d", i), S_SD, 0);
            exp_sig($sformatf("t4_asd%0d", i), S_ASD, sd_in);
            exp_sig($sformatf("t4_bsd%0d", i), S_BSD, 0);
            exp_sig($sformatf("t4_err%0d", i), S_ERR, 0);
            tick();
        end
        b_sde_in = 0; b_dl_in = 0; b_ul_in = 0; b_sd_in = 0;
        exp_sig("t4_to_err", S_ERR, 1);
        exp_sig("t4_to_code", S_CODE, 1);
        exp_sig("t4_to_agnt", S_AGNT, 0);
        exp_sig("t4_to_bgnt", S_BGNT, 0);
        tick();
        exp_sig("t4_err_once", S_ERR, 0);
        exp_sig("t4_idle_own", S_OWN, 0);
        tick();
        b_req_in = 0;
        exp_sig("t4_b_gnt", S_BGNT, 1);
        exp_sig("t4_a_blocked", S_AGNT, 0);
        exp_sig("t4_code_hold", S_CODE, 1);
        tick();
        exp_sig("t4_gap_own", S_OWN, 0);
        tick();
        exp_sig("t4_blk_own0", S_OWN, 0);
        tick();
        exp_sig("t4_blk_agnt1", S_AGNT, 0);
        tick();
        a_req_in = 0;
        tick();
        a_req_in = 1;
        exp_sig("t4_rereq_pre", S_AGNT, 0);
        tick();
        a_ul_in = 1;
        exp_sig("t4_regrant", S_AGNT, 1);
        exp_sig("t4_regrant_own", S_OWN, 1);
        tick();
        a_ul_in = 0;

        // reset mid-shift, then a clean B transfer
        for (int i = 0; i < 4; i++) begin
            a_sde_in = 1;
            a_sd_in  = 1'($urandom_range(0, 1));
            tick();
        end
        a_sde_in = 1; a_sd_in = 1; sd_in = 1;
        rst_n = 1'b0;
        exp_all_zero("t5_rst");
        tick();
        rst_n = 1'b1;
        a_req_in = 0; a_sde_in = 0; a_sd_in = 0;
        b_req_in = 1;
        tick();
        for (int i = 0; i < CL; i++) begin
            b_sde_in = 1;
            if (i == 0) exp_sig("t5_b_gnt", S_BGNT, 1);
            tick();
        end
        b_sde_in = 0;
        b_dl_in = 1;
        exp_sig("t5_dl", S_DL, 1);
        tick();
        b_dl_in = 0; b_req_in = 0;
        exp_sig("t5_err", S_ERR, 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
